// File: rtl/add_sub_sequencer_if.sv
// ============================================================================
//  Module   : add_sub_sequencer_if
//  Purpose  : Bundles the operator inputs, the datapath return path and the
//             sequencer outputs of the add/sub lab-board front end.
//  Modports : master - the sequencer (consumes clicks/datapath, drives operands)
//             slave  - the environment (board inputs plus the add/sub datapath)
//  Signals  : rot_event, rot_dir, slide[3:0], dp_sum[WIDTH-1:0], dp_carry,
//             a_out, b_out, opcode_out, result, result_flag, result_valid,
//             state_out[2:0]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface add_sub_sequencer_if #(
   parameter int WIDTH = 7
);
   logic             rot_event;
   logic             rot_dir;
   logic [3:0]       slide;
   logic [WIDTH-1:0] dp_sum;
   logic             dp_carry;
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic             opcode_out;
   logic [WIDTH-1:0] result;
   logic             result_flag;
   logic             result_valid;
   logic [2:0]       state_out;

   modport master (
      input  rot_event, rot_dir, slide, dp_sum, dp_carry,
      output a_out, b_out, opcode_out, result, result_flag, result_valid, state_out
   );

   modport slave (
      output rot_event, rot_dir, slide, dp_sum, dp_carry,
      input  a_out, b_out, opcode_out, result, result_flag, result_valid, state_out
   );
endinterface

`default_nettype wire

// File: rtl/add_sub_sequencer.sv
// ============================================================================
//  Module   : add_sub_sequencer
//  Purpose  : Front-end controller for the combinational add/sub datapath.
//             Walks operand entry (A low/high, B low/high, opcode) on rotary
//             clicks, drives registered operands to the datapath, allows one
//             settle cycle, then latches the datapath result and flag.
//  Ports    : clk  - system clock, all state updates on rising edge
//             rst  - asynchronous, active-high reset
//             bus  - add_sub_sequencer_if.master (inputs: rot_event, rot_dir,
//                    slide, dp_sum, dp_carry; outputs: a_out, b_out,
//                    opcode_out, result, result_flag, result_valid, state_out)
//  Notes    : WIDTH must lie in 5..8 so the high field fits in one slide value.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sub_sequencer #(
   parameter int               WIDTH   = 7,
   parameter logic [WIDTH-1:0] A_RESET = 7'h7F,
   parameter logic [WIDTH-1:0] B_RESET = 7'h00
) (
   input  wire logic            clk,
   input  wire logic            rst,
   add_sub_sequencer_if.master  bus
);

   localparam int c_HI_W = WIDTH - 4;

   typedef enum logic [2:0] {
      S_A_LO = 3'd0,
      S_A_HI = 3'd1,
      S_B_LO = 3'd2,
      S_B_HI = 3'd3,
      S_OP   = 3'd4,
      S_EXEC = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t           r_state;
   logic             r_prev_rot;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_opcode;
   logic [WIDTH-1:0] r_result;
   logic             r_flag;
   logic             r_valid;
   logic             w_click;

   // A level held high for many cycles produces a single click on its rise.
   assign w_click = bus.rot_event & ~r_prev_rot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_A_LO;
         r_prev_rot <= 1'b0;
         r_a        <= A_RESET;
         r_b        <= B_RESET;
         r_opcode   <= 1'b0;
         r_result   <= '0;
         r_flag     <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         // Edge register tracks the input every cycle, EXEC included, so a
         // click swallowed during EXEC is not replayed afterwards.
         r_prev_rot <= bus.rot_event;

         case (r_state)
            S_EXEC: begin
               // Operands have been stable for a full cycle; capture the
               // datapath output verbatim.
               r_result <= bus.dp_sum;
               r_flag   <= bus.dp_carry;
               r_valid  <= 1'b1;
               r_state  <= S_DONE;
            end

            S_A_LO, S_A_HI, S_B_LO, S_B_HI, S_OP, S_DONE: begin
               if (w_click) begin
                  if (bus.rot_dir) begin
                     // Restart keeps the operands so partial entry can be redone.
                     r_state <= S_A_LO;
                     r_valid <= 1'b0;
                  end else begin
                     case (r_state)
                        S_A_LO: begin
                           r_a[3:0] <= bus.slide;
                           r_state  <= S_A_HI;
                        end
                        S_A_HI: begin
                           r_a[WIDTH-1:4] <= bus.slide[c_HI_W-1:0];
                           r_state        <= S_B_LO;
                        end
                        S_B_LO: begin
                           r_b[3:0] <= bus.slide;
                           r_state  <= S_B_HI;
                        end
                        S_B_HI: begin
                           r_b[WIDTH-1:4] <= bus.slide[c_HI_W-1:0];
                           r_state        <= S_OP;
                        end
                        S_OP: begin
                           r_opcode <= bus.slide[0];
                           r_valid  <= 1'b0;
                           r_state  <= S_EXEC;
                        end
                        S_DONE: begin
                           r_valid <= 1'b0;
                           r_state <= S_A_LO;
                        end
                        default: r_state <= S_A_LO;
                     endcase
                  end
               end
            end

            // Encoding 7 is unused; fall back to the start of entry.
            default: r_state <= S_A_LO;
         endcase
      end
   end

   assign bus.a_out        = r_a;
   assign bus.b_out        = r_b;
   assign bus.opcode_out   = r_opcode;
   assign bus.result       = r_result;
   assign bus.result_flag  = r_flag;
   assign bus.result_valid = r_valid;
   assign bus.state_out    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_add_sub_sequencer.sv
// ============================================================================
//  Module   : tb_add_sub_sequencer
//  Purpose  : Self-checking bench for add_sub_sequencer with a behavioural
//             7-bit add/sub datapath closing the loop on dp_sum/dp_carry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_sub_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   add_sub_sequencer_if #(.WIDTH(7)) bus();

   add_sub_sequencer #(
      .WIDTH  (7),
      .A_RESET(7'h7F),
      .B_RESET(7'h00)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Datapath: carry-out on add, signed overflow on subtract.
   logic [7:0] w_add;
   logic [6:0] w_diff;
   always_comb begin
      w_add  = {1'b0, bus.a_out} + {1'b0, bus.b_out};
      w_diff = bus.a_out - bus.b_out;
      if (bus.opcode_out) begin
         bus.dp_sum   = w_diff;
         bus.dp_carry = (bus.a_out[6] != bus.b_out[6]) && (w_diff[6] != bus.a_out[6]);
      end else begin
         bus.dp_sum   = w_add[6:0];
         bus.dp_carry = w_add[7];
      end
   end

   typedef struct packed {
      logic [6:0] res;
      logic       flag;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pops one expectation on every new result.
   initial begin
      logic pv;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0;
         end else begin
            if (bus.result_valid && !pv) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got %0h with no expectation", bus.result);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  check("result", 32'(bus.result), 32'(e.res));
                  check("result_flag", 32'(bus.result_flag), 32'(e.flag));
                  check("state_done", 32'(bus.state_out), 32'd6);
               end
            end
            pv = bus.result_valid;
         end
      end
   end

   // Called 1 time unit after a rising edge; returns 1 time unit after the
   // edge that follows the one that sampled the click.
   task automatic click(input logic dir, input logic [3:0] sw);
      bus.rot_event = 1'b1;
      bus.rot_dir   = dir;
      bus.slide     = sw;
      @(posedge clk); #1;
      bus.rot_event = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic enter_operands(input logic [6:0] a, input logic [6:0] b);
      click(1'b0, a[3:0]);
      click(1'b0, {1'b0, a[6:4]});
      click(1'b0, b[3:0]);
      click(1'b0, {1'b0, b[6:4]});
   endtask

   task automatic run_op(input logic [6:0] a, input logic [6:0] b, input logic op,
                         input logic [6:0] exp_res, input logic exp_flag, input logic exit_dir);
      q.push_back({exp_res, exp_flag});
      enter_operands(a, b);
      check("a_out_entry", 32'(bus.a_out), 32'(a));
      check("b_out_entry", 32'(bus.b_out), 32'(b));
      check("state_op", 32'(bus.state_out), 32'd4);
      click(1'b0, {3'b000, op});
      check("opcode_out", 32'(bus.opcode_out), 32'(op));
      for (int i = 0; i < 8 && bus.state_out != 3'd6; i++) @(negedge clk);
      check("done_reached", 32'(bus.state_out), 32'd6);
      @(posedge clk); #1;
      click(exit_dir, 4'h0);
      check("exit_state", 32'(bus.state_out), 32'd0);
      check("exit_valid", 32'(bus.result_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rot_event = 1'b0;
      bus.rot_dir   = 1'b0;
      bus.slide     = 4'h0;
      rst           = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_a_out", 32'(bus.a_out), 32'h7F);
      check("rst_b_out", 32'(bus.b_out), 32'h00);
      check("rst_opcode", 32'(bus.opcode_out), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_flag", 32'(bus.result_flag), 32'd0);
      check("rst_valid", 32'(bus.result_valid), 32'd0);
      check("rst_state", 32'(bus.state_out), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(7'h05, 7'h03, 1'b0, 7'h08, 1'b0, 1'b0);
      run_op(7'h7F, 7'h01, 1'b0, 7'h00, 1'b1, 1'b0);
      run_op(7'h10, 7'h20, 1'b1, 7'h70, 1'b0, 1'b0);
      run_op(7'h2A, 7'h15, 1'b0, 7'h3F, 1'b0, 1'b0);
      run_op(7'h40, 7'h01, 1'b1, 7'h3F, 1'b1, 1'b0);

      // Held rot_event: one advance only (a was 40, low nibble becomes 5).
      bus.rot_event = 1'b1;
      bus.rot_dir   = 1'b0;
      bus.slide     = 4'h5;
      repeat (20) @(posedge clk);
      #1 bus.rot_event = 1'b0;
      @(posedge clk); #1;
      check("hold_state", 32'(bus.state_out), 32'd1);
      check("hold_a_out", 32'(bus.a_out), 32'h45);

      // Restart from B_HI keeps operands.
      click(1'b0, 4'h2);
      click(1'b0, 4'h9);
      check("bhi_state", 32'(bus.state_out), 32'd3);
      click(1'b1, 4'hF);
      check("restart_state", 32'(bus.state_out), 32'd0);
      check("restart_a_out", 32'(bus.a_out), 32'h25);
      check("restart_b_out", 32'(bus.b_out), 32'h09);
      check("restart_opcode", 32'(bus.opcode_out), 32'd1);

      // Restart out of DONE clears result_valid.
      run_op(7'h01, 7'h01, 1'b0, 7'h02, 1'b0, 1'b1);

      // Reset asserted during EXEC, with rot_event rising in that cycle.
      enter_operands(7'h12, 7'h34);
      bus.rot_event = 1'b1;
      bus.slide     = 4'h0;
      @(posedge clk); #1;
      bus.rot_event = 1'b0;
      check("pre_rst_exec", 32'(bus.state_out), 32'd5);
      rst = 1'b1;
      #2 bus.rot_event = 1'b1;
      #1;
      check("exec_rst_valid", 32'(bus.result_valid), 32'd0);
      check("exec_rst_a_out", 32'(bus.a_out), 32'h7F);
      check("exec_rst_state", 32'(bus.state_out), 32'd0);
      check("exec_rst_result", 32'(bus.result), 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus.rot_event = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_state", 32'(bus.state_out), 32'd0);
      check("post_rst_b_out", 32'(bus.b_out), 32'h00);

      repeat (2) @(posedge clk);
      check("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
